// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation encodings and FSM states.
package alu_pkg;

    // Operation encodings presented on ALUOp.
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Controller states. The encoding is also the value seen on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the encodings the datapath understands.
    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/ALU_1_bit.sv
// One-bit ALU slice: AND, OR, ADD and NOR on single bits. Subtraction is
// formed by the caller (inverted B, carry-in 1); unknown ops give 0.
module ALU_1_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [3:0] op,
    output logic       result,
    output logic       carry_out
);

    // Combinational bit function and full-adder carry.
    always_comb begin
        result    = 1'b0;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a ^ b ^ carry_in;
            OP_NOR:  result = ~(a | b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes one operand bit per cycle, LSB first, through a
// single ALU_1_bit slice. Carry chain, result masking and flags live here.
//
// Handshake: start is sampled only in IDLE; an accepted start latches a, b and
// ALUOp. busy stays high through RUN and DONE, and done is a one-cycle pulse in
// DONE when result and flags are valid. result/flags hold until the next
// accepted start. start while busy is ignored. Intended for WIDTH >= 2.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;

    logic             is_sub;
    logic             is_arith;
    logic [3:0]       slice_op;
    logic             slice_b;
    logic             slice_res;
    logic             slice_cout;
    logic             bit_res;
    logic             last_bit;
    logic [WIDTH-1:0] next_result;

    ALU_1_bit u_slice (
        .a         (a_sh[0]),
        .b         (slice_b),
        .carry_in  (carry_q),
        .op        (slice_op),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    // Operand conditioning for the slice and result-bit masking.
    always_comb begin
        is_sub      = (op_q == OP_SUB);
        is_arith    = (op_q == OP_ADD) || is_sub;
        slice_op    = is_sub ? OP_ADD : op_q;
        slice_b     = is_sub ? ~b_sh[0] : b_sh[0];
        bit_res     = op_supported(op_q) ? slice_res : 1'b0;
        last_bit    = (cnt_q == CW'(WIDTH - 1));
        next_result = (result >> 1) | (WIDTH'(bit_res) << (WIDTH - 1));
    end

    assign busy  = (state_q == RUN) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign state = state_q;

    // Controller and serial datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        a_sh      <= a;
                        b_sh      <= b;
                        op_q      <= ALUOp;
                        cnt_q     <= '0;
                        carry_q   <= (ALUOp == OP_SUB);
                        result    <= '0;
                        zero      <= 1'b0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    result  <= next_result;
                    carry_q <= slice_cout;
                    if (last_bit) begin
                        // carry_q still holds the carry into the MSB here.
                        state_q   <= DONE;
                        zero      <= (next_result == '0);
                        carry_out <= is_arith & slice_cout;
                        overflow  <= is_arith & (carry_q ^ slice_cout);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed testbench for bit_serial_alu at WIDTH=64.
module tb_bit_serial_alu;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry_out;
    logic         overflow;
    logic [1:0]   dut_state;

    int checks = 0;
    int errors = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ALUOp     (alu_op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow),
        .state     (dut_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an operation for one cycle; returns #1 after the sampling edge.
    task automatic launch(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done (elapsed = edges already seen since the start edge),
    // then check latency, result, flags and the post-done behaviour.
    task automatic finish_op(input string tag, input int elapsed, input logic [W-1:0] exp_res,
                             input logic exp_zero, input logic exp_cout, input logic exp_ovf);
        int k;
        k = elapsed;
        while (k < 80 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " latency"}, W'(k), W'(64));
        check({tag, " result"}, result, exp_res);
        check({tag, " zero"}, W'(zero), W'(exp_zero));
        check({tag, " carry_out"}, W'(carry_out), W'(exp_cout));
        check({tag, " overflow"}, W'(overflow), W'(exp_ovf));
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, W'(done), W'(0));
        check({tag, " busy_after"}, W'(busy), W'(0));
        check({tag, " result_held"}, result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] exp_res,
                          input logic exp_zero, input logic exp_cout, input logic exp_ovf);
        launch(op, va, vb);
        check({tag, " busy"}, W'(busy), W'(1));
        finish_op(tag, 0, exp_res, exp_zero, exp_cout, exp_ovf);
    endtask

    initial begin
        int done_seen;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        alu_op = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst result", result, '0);
        check("rst flags", W'({zero, carry_out, overflow}), W'(0));
        check("rst state", W'(dut_state), W'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op("add5+3", 4'b0010, 64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 1'b0);
        run_op("sub3-5", 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub5-5", 4'b0110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1'b0);
        run_op("addmax+1", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0);
        run_op("addovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        run_op("subovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
        run_op("nor0", 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("and", 4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0);
        run_op("or", 4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0);
        run_op("andcarry", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("badop", 4'b0011, 64'd5, 64'd3, 64'd0, 1'b1, 1'b0, 1'b0);

        // Second start while busy is ignored.
        launch(4'b0010, 64'd100, 64'd23);
        repeat (9) @(posedge clk);
        #1;
        start  = 1'b1;
        alu_op = 4'b0110;
        a      = 64'd1;
        b      = 64'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op("ignore_busy", 10, 64'd123, 1'b0, 1'b0, 1'b0);

        // start raised during the DONE cycle is ignored.
        launch(4'b0010, 64'd1, 64'd1);
        begin
            int k;
            k = 0;
            while (k < 80 && done !== 1'b1) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("done_cycle latency", W'(k), W'(64));
        end
        start  = 1'b1;
        alu_op = 4'b0010;
        a      = 64'd7;
        b      = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_cycle start_ignored", W'(busy), W'(0));
        check("done_cycle result", result, 64'd2);
        @(posedge clk);
        #1;
        check("done_cycle still_idle", W'(busy), W'(0));

        // Reset mid-operation aborts with no done pulse.
        launch(4'b0010, 64'd9, 64'd9);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort result", result, '0);
        check("abort flags", W'({zero, carry_out, overflow}), W'(0));
        check("abort state", W'(dut_state), W'(0));
        done_seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("abort no_done", W'(done_seen), W'(0));
        run_op("after_abort", 4'b0010, 64'd40, 64'd2, 64'd42, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand and result width in bits, LSB processed first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 ALUOp  input  4  operation code; captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN and DONE states).
REQ-009 done  output  1  single-cycle pulse marking result and flags valid.
REQ-010 result  output  WIDTH  operation result; holds its value until the next accepted start.
REQ-011 zero  output  1  high when result is all zeros; valid with done and held after it.
REQ-012 carry_out  output  1  carry out of bit WIDTH-1 for ADD/SUB, else 0.
REQ-013 overflow  output  1  signed overflow for ADD/SUB (carry into MSB XOR carry out of MSB), else 0.

Function
REQ-014 Supported ALUOp encodings: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B), 1100 NOR.
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the bit WIDTH-1 cycle; DONE->IDLE unconditionally after one cycle.
REQ-016 Accepted start loads operand shift registers, the latched op, bit counter=0, and the carry flop (1 for SUB, 0 otherwise).
REQ-017 In RUN, each cycle processes exactly one bit (counter value), shifts A/B right by one, and shifts the slice result into result bit WIDTH-1 while shifting result right.
REQ-018 SUB is executed as ADD of A, inverted B bit, and carry-in 1; the slice sees op 0010.
REQ-019 The carry flop takes the slice carry each RUN cycle; the value before the final bit is kept for overflow.
REQ-020 Latency: start sampled in cycle T gives done=1 in cycle T+WIDTH+1, exactly one cycle wide.
REQ-021 start asserted while busy=1 is ignored, with no effect on operands, op or timing.
REQ-022 start in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.
REQ-023 Unsupported ALUOp: same latency, result all zeros, zero=1, carry_out=0, overflow=0.
REQ-024 For AND/OR/NOR, carry_out and overflow SHALL be 0 regardless of slice carry.
REQ-025 Bit counter width is ceil(log2(WIDTH)) and it never wraps during RUN.

Reset
REQ-026 reset=1 forces IDLE, busy=0, done=0, result=0, zero=0, carry_out=0, overflow=0, counter=0, carry flop=0.
REQ-027 reset asserted during RUN or DONE aborts the operation; no done pulse follows.
REQ-028 reset has priority over start in the same cycle.

Structure
REQ-029 A shared package alu_pkg holds the ALUOp encoding constants and the FSM state enum.
REQ-030 Per-bit computation uses one instance of the team's existing ALU_1_bit slice.
REQ-031 Carry-chain, masking and flag logic live in bit_serial_alu and not in the slice.

Verification
REQ-032 WIDTH=64, ADD a=5 b=3 -> done at T+65, result=8, zero=0, carry_out=0, overflow=0.
REQ-033 SUB a=3 b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0; SUB a=5 b=5 -> result=0, zero=1, carry_out=1.
REQ-034 ADD a=0xFFFF_FFFF_FFFF_FFFF b=1 -> result=0, zero=1, carry_out=1, overflow=0; ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> overflow=1.
REQ-035 NOR a=0 b=0 -> all ones; AND a=0xF0 b=0x3C -> 0x30 with carry_out=0 and overflow=0.
REQ-036 start pulsed again at T+10 with different operands -> ignored; first result unchanged; done still at T+65.
REQ-037 reset at T+20 -> next cycle IDLE with all outputs 0, no done pulse; new ADD completes normally.
